mbinit_repair_partner_gen: RTL and testbench

MBINIT_REPAIR_PARTNER_GEN -- requirements
Module: mbinit_repair_partner_gen

---
 rtl/mbinit_repair_partner_gen.sv | 150 +++++++++++++++
 tb/tb_mbinit_repair_partner_gen.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbinit_repair_partner_gen.sv
// MBINIT repair partner: answers the remote init/result/done handshake over the
// sideband, reports the captured detection result and guards every wait state
// with a watchdog that drops into ERROR when the partner stalls.
module mbinit_repair_partner_gen #(
   parameter int unsigned RESULT_W    = 3,
   parameter logic [3:0]  MSG_BASE    = 4'b0001,
   parameter int unsigned TIMEOUT_CYC = 1024,
   parameter int unsigned MAX_RESULTS = 15
) (
   input  logic                CLK,
   input  logic                rst_n,
   input  logic                i_enable,
   input  logic [RESULT_W-1:0] i_result,
   input  logic [3:0]          i_rx_msg,
   input  logic                i_msg_valid,
   input  logic                i_busy,
   input  logic                i_busy_fall,
   output logic [3:0]          o_tx_msg,
   output logic                o_tx_valid,
   output logic [RESULT_W-1:0] o_result,
   output logic                o_clear_detect,
   output logic                o_done,
   output logic                o_timeout,
   output logic [3:0]          o_result_cnt
);

   localparam int unsigned    WD_W    = $clog2(TIMEOUT_CYC);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [3:0]     MAX_CNT = 4'(MAX_RESULTS);

   // Opcodes wrap modulo 16 because the arithmetic is done in 4 bits.
   localparam logic [3:0] OP_INIT_REQ    = MSG_BASE;
   localparam logic [3:0] OP_INIT_RESP   = MSG_BASE + 4'd1;
   localparam logic [3:0] OP_RESULT_REQ  = MSG_BASE + 4'd2;
   localparam logic [3:0] OP_RESULT_RESP = MSG_BASE + 4'd3;
   localparam logic [3:0] OP_DONE_REQ    = MSG_BASE + 4'd4;
   localparam logic [3:0] OP_DONE_RESP   = MSG_BASE + 4'd5;

   typedef enum logic [3:0] {
      IDLE, WAIT_INIT, BUSY_INIT, SEND_INIT, WAIT_REQ, BUSY_RES,
      SEND_RES, BUSY_DONE, SEND_DONE, DONE, ERROR
   } state_t;

   state_t          state_reg, state_next;
   logic [WD_W-1:0] wd_reg;
   logic            wd_active, wd_expired;
   logic            tx_valid_next, clear_next, done_next, timeout_next;
   logic [3:0]      tx_msg_next;

   // Next-state selection plus output decode of the state being entered.
   always_comb begin
      state_next    = state_reg;
      wd_active     = 1'b0;
      wd_expired    = 1'b0;
      tx_valid_next = 1'b0;
      tx_msg_next   = 4'd0;
      clear_next    = 1'b0;
      done_next     = 1'b0;
      timeout_next  = 1'b0;

      wd_active  = (state_reg != IDLE) && (state_reg != DONE) && (state_reg != ERROR);
      wd_expired = wd_active && (wd_reg == WD_LAST);

      // Message-driven moves are tested before expiry so a message wins a tie.
      case (state_reg)
         IDLE:      if (i_enable) state_next = WAIT_INIT;
         WAIT_INIT: begin
            if (i_msg_valid && i_rx_msg == OP_INIT_REQ) state_next = BUSY_INIT;
            else if (wd_expired)                        state_next = ERROR;
         end
         BUSY_INIT: if (!i_busy) state_next = SEND_INIT; else if (wd_expired) state_next = ERROR;
         BUSY_RES:  if (!i_busy) state_next = SEND_RES;  else if (wd_expired) state_next = ERROR;
         BUSY_DONE: if (!i_busy) state_next = SEND_DONE; else if (wd_expired) state_next = ERROR;
         SEND_INIT: if (i_busy_fall) state_next = WAIT_REQ; else if (wd_expired) state_next = ERROR;
         SEND_RES:  if (i_busy_fall) state_next = WAIT_REQ; else if (wd_expired) state_next = ERROR;
         SEND_DONE: if (i_busy_fall) state_next = DONE;     else if (wd_expired) state_next = ERROR;
         WAIT_REQ: begin
            if (i_msg_valid) begin
               if (i_rx_msg == OP_RESULT_REQ)
                  state_next = (o_result_cnt == MAX_CNT) ? ERROR : BUSY_RES;
               else if (i_rx_msg == OP_DONE_REQ)
                  state_next = BUSY_DONE;
               else
                  state_next = ERROR;
            end else if (wd_expired) begin
               state_next = ERROR;
            end
         end
         DONE:    state_next = DONE;
         ERROR:   state_next = ERROR;
         default: state_next = IDLE;
      endcase

      // Losing enable overrides everything else.
      if (state_reg != IDLE && !i_enable) state_next = IDLE;

      case (state_next)
         SEND_INIT: begin tx_valid_next = 1'b1; tx_msg_next = OP_INIT_RESP; clear_next = 1'b1; end
         SEND_RES:  begin tx_valid_next = 1'b1; tx_msg_next = OP_RESULT_RESP; end
         SEND_DONE: begin tx_valid_next = 1'b1; tx_msg_next = OP_DONE_RESP; end
         DONE:      done_next    = 1'b1;
         ERROR:     timeout_next = 1'b1;
         default:   ;
      endcase
   end

   // State register.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Watchdog restarts on every state change and runs only in waiting states.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n)                       wd_reg <= '0;
      else if (state_next != state_reg) wd_reg <= '0;
      else if (wd_active)               wd_reg <= wd_reg + WD_W'(1);
   end

   // Registered outputs; the result is latched once on entry to SEND_RES.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         o_tx_valid     <= 1'b0;
         o_tx_msg       <= 4'd0;
         o_clear_detect <= 1'b0;
         o_done         <= 1'b0;
         o_timeout      <= 1'b0;
         o_result       <= '0;
      end else begin
         o_tx_valid     <= tx_valid_next;
         o_tx_msg       <= tx_msg_next;
         o_clear_detect <= clear_next;
         o_done         <= done_next;
         o_timeout      <= timeout_next;
         if (state_next != SEND_RES)      o_result <= '0;
         else if (state_reg != SEND_RES)  o_result <= i_result;
      end
   end

   // Count completed result responses for this session, saturating at 15.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n)
         o_result_cnt <= 4'd0;
      else if (state_next == IDLE || state_next == WAIT_INIT)
         o_result_cnt <= 4'd0;
      else if (state_reg == SEND_RES && state_next == WAIT_REQ && o_result_cnt != 4'hF)
         o_result_cnt <= o_result_cnt + 4'd1;
   end

endmodule

// File: tb/tb_mbinit_repair_partner_gen.sv
// Directed bench for mbinit_repair_partner_gen with a wrapped opcode base,
// a short watchdog and a two-result session limit.
module tb_mbinit_repair_partner_gen;

   logic       CLK = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_enable = 1'b0;
   logic [2:0] i_result = 3'd0;
   logic [3:0] i_rx_msg = 4'd0;
   logic       i_msg_valid = 1'b0;
   logic       i_busy = 1'b0;
   logic       i_busy_fall = 1'b0;
   logic [3:0] o_tx_msg;
   logic       o_tx_valid;
   logic [2:0] o_result;
   logic       o_clear_detect;
   logic       o_done;
   logic       o_timeout;
   logic [3:0] o_result_cnt;

   // Base 4'hB: opcodes B,C,D,E,F and done_resp wraps to 0.
   localparam logic [3:0] INIT_REQ  = 4'hB;
   localparam logic [3:0] INIT_RESP = 4'hC;
   localparam logic [3:0] RES_REQ   = 4'hD;
   localparam logic [3:0] RES_RESP  = 4'hE;
   localparam logic [3:0] DONE_REQ  = 4'hF;
   localparam logic [3:0] DONE_RESP = 4'h0;

   mbinit_repair_partner_gen #(
      .RESULT_W(3), .MSG_BASE(4'b1011), .TIMEOUT_CYC(16), .MAX_RESULTS(2)
   ) dut (
      .CLK(CLK), .rst_n(rst_n), .i_enable(i_enable), .i_result(i_result),
      .i_rx_msg(i_rx_msg), .i_msg_valid(i_msg_valid), .i_busy(i_busy),
      .i_busy_fall(i_busy_fall), .o_tx_msg(o_tx_msg), .o_tx_valid(o_tx_valid),
      .o_result(o_result), .o_clear_detect(o_clear_detect), .o_done(o_done),
      .o_timeout(o_timeout), .o_result_cnt(o_result_cnt)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0] msg;
      logic [2:0] res;
      logic       clr;
   } exp_t;
   exp_t sb_q[$];

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag, input logic [3:0] cnt);
      chk({tag, "_txv"}, o_tx_valid, 0);
      chk({tag, "_txm"}, o_tx_msg, 0);
      chk({tag, "_res"}, o_result, 0);
      chk({tag, "_clr"}, o_clear_detect, 0);
      chk({tag, "_done"}, o_done, 0);
      chk({tag, "_tmo"}, o_timeout, 0);
      chk({tag, "_cnt"}, o_result_cnt, cnt);
   endtask

   task automatic send(input logic [3:0] op);
      i_rx_msg    = op;
      i_msg_valid = 1'b1;
      step();
      i_msg_valid = 1'b0;
      i_rx_msg    = 4'd0;
   endtask

   task automatic pulse_fall();
      i_busy_fall = 1'b1;
      step();
      i_busy_fall = 1'b0;
   endtask

   task automatic expect_tx(input string tag);
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         if (o_tx_valid === 1'b1) break;
         step();
      end
      chk({tag, "_valid"}, o_tx_valid, 1);
      chk({tag, "_sbq"}, sb_q.size(), 1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk({tag, "_msg"}, o_tx_msg, e.msg);
         chk({tag, "_result"}, o_result, e.res);
         chk({tag, "_clear"}, o_clear_detect, e.clr);
         $display("TX %s msg=%h result=%b clear=%b cnt=%0d", tag, o_tx_msg, o_result,
                  o_clear_detect, o_result_cnt);
      end
   endtask

   task automatic do_result(input string tag, input logic [2:0] r, input logic [3:0] cnt_after);
      i_result = r;
      sb_q.push_back({RES_RESP, r, 1'b0});
      send(RES_REQ);
      expect_tx(tag);
      pulse_fall();
      chk({tag, "_cnt"}, o_result_cnt, cnt_after);
      chk({tag, "_txv0"}, o_tx_valid, 0);
   endtask

   task automatic do_init(input string tag);
      sb_q.push_back({INIT_RESP, 3'b000, 1'b1});
      send(INIT_REQ);
      expect_tx(tag);
      pulse_fall();
      chk({tag, "_txv0"}, o_tx_valid, 0);
   endtask

   initial begin
      // Reset and idle with enable low
      step(); step();
      chk_quiet("reset", 4'd0);
      rst_n = 1'b1;
      repeat (20) step();
      chk_quiet("idle_no_enable", 4'd0);

      // Nominal session
      i_enable = 1'b1;
      step();
      do_init("init");
      i_result = 3'b101;
      sb_q.push_back({RES_RESP, 3'b101, 1'b0});
      send(RES_REQ);
      expect_tx("res_nominal");
      i_result = 3'b000;
      step();
      chk("res_stable", o_result, 3'b101);
      chk("res_stable_txv", o_tx_valid, 1);
      pulse_fall();
      chk("nominal_cnt", o_result_cnt, 1);
      chk("nominal_res_cleared", o_result, 0);
      sb_q.push_back({DONE_RESP, 3'b000, 1'b0});
      send(DONE_REQ);
      expect_tx("done_resp");
      pulse_fall();
      chk("done_flag", o_done, 1);
      chk("done_txv", o_tx_valid, 0);
      repeat (20) step();
      chk("done_hold", o_done, 1);
      chk("done_no_tmo", o_timeout, 0);
      chk("done_cnt", o_result_cnt, 1);
      i_enable = 1'b0;
      step();
      chk_quiet("after_done", 4'd0);

      // Busy held for five cycles after init_req
      i_enable = 1'b1;
      step();
      i_busy = 1'b1;
      sb_q.push_back({INIT_RESP, 3'b000, 1'b1});
      send(INIT_REQ);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("busy_hold%0d", k), o_tx_valid, 0);
         step();
      end
      chk("busy_last", o_tx_valid, 0);
      i_busy = 1'b0;
      step();
      chk("busy_release_txv", o_tx_valid, 1);
      expect_tx("init_busy");
      pulse_fall();

      // Stray busy_fall in WAIT_REQ, then session limit of two results
      pulse_fall();
      chk("stray_fall_txv", o_tx_valid, 0);
      chk("stray_fall_tmo", o_timeout, 0);
      do_result("res_a", 3'b011, 4'd1);
      do_result("res_b", 3'b110, 4'd2);
      send(RES_REQ);
      chk("max_err_tmo", o_timeout, 1);
      chk("max_err_txv", o_tx_valid, 0);
      repeat (20) step();
      chk("max_err_hold", o_timeout, 1);
      chk("max_err_cnt", o_result_cnt, 2);
      i_enable = 1'b0;
      step();
      chk_quiet("after_max_err", 4'd0);

      // Watchdog expiry in WAIT_INIT; an unrelated opcode must not restart it
      i_enable = 1'b1;
      step();
      for (int k = 1; k <= 16; k++) begin
         if (k == 3) begin
            i_rx_msg    = RES_REQ;
            i_msg_valid = 1'b1;
         end
         step();
         i_msg_valid = 1'b0;
         i_rx_msg    = 4'd0;
         chk($sformatf("wd_cycle%0d", k), o_timeout, (k == 16) ? 1 : 0);
      end
      i_enable = 1'b0;
      step();
      chk_quiet("after_wd", 4'd0);

      // init_req on the expiry cycle wins over the watchdog
      i_enable = 1'b1;
      step();
      repeat (15) step();
      chk("race_pre_tmo", o_timeout, 0);
      sb_q.push_back({INIT_RESP, 3'b000, 1'b1});
      send(INIT_REQ);
      chk("race_tmo", o_timeout, 0);
      expect_tx("init_race");
      pulse_fall();

      // Enable dropped during SEND_RES
      do_result("res_c", 3'b111, 4'd1);
      i_result = 3'b010;
      sb_q.push_back({RES_RESP, 3'b010, 1'b0});
      send(RES_REQ);
      expect_tx("res_abort");
      i_enable = 1'b0;
      step();
      chk_quiet("abort_send_res", 4'd0);

      // Protocol error: init_req while waiting for a request
      i_enable = 1'b1;
      step();
      do_init("init_proto");
      send(INIT_REQ);
      chk("proto_err_tmo", o_timeout, 1);
      i_enable = 1'b0;
      step();
      chk_quiet("after_proto", 4'd0);

      // Asynchronous reset in WAIT_REQ
      i_enable = 1'b1;
      step();
      do_init("init_rst");
      do_result("res_rst", 3'b001, 4'd1);
      rst_n = 1'b0;
      #1;
      chk_quiet("async_reset", 4'd0);
      i_enable = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      chk_quiet("post_reset", 4'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench did not finish");
   end

endmodule
